// File: rtl/axis_video_frame_sink.sv
// axis_video_frame_sink: AXI4-Stream video sink with backpressure, coordinate tracking, geometry checks and frame stats
//   clk, reset (async, active-high)
//   iStallPeriod : tready stall pattern, one stall every iStallPeriod+1 cycles (0 = never)
//   iClearErr    : clears sticky error flags (a simultaneous set wins)
//   s_axis_*     : video input, tuser = start of frame, tlast = end of line
//   oValid/oData/oX/oY : accepted pixel with its coordinates, one cycle after the transfer
//   oEndOfFrame/oFrameCnt/oFrameSum : frame completion pulse, frame count, sum of last frame
//   oErr*        : sticky geometry error flags
module axis_video_frame_sink #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            iStallPeriod,
    input  logic                  iClearErr,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  oValid,
    output logic [DATA_WIDTH-1:0] oData,
    output logic [15:0]           oX,
    output logic [15:0]           oY,
    output logic                  oEndOfFrame,
    output logic [15:0]           oFrameCnt,
    output logic [31:0]           oFrameSum,
    output logic                  oErrSof,
    output logic                  oErrEolEarly,
    output logic                  oErrEolLate,
    output logic                  oErrHeight
);
    typedef enum logic {S_WAIT_SOF, S_ACTIVE} state_t;

    localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

    state_t                state_q;
    logic [3:0]            stall_q, stall_d;
    logic                  ready_q, ready_d;
    logic [15:0]           x_q, y_q, cx, cy;
    logic [31:0]           sum_q, sum_d;
    logic                  valid_q, eof_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [15:0]           ox_q, oy_q, cnt_q;
    logic [31:0]           fsum_q;
    logic                  err_sof_q, err_early_q, err_late_q, err_h_q;
    logic                  xfer, accept, at_xl, eol, eof;
    logic                  set_sof, set_early, set_late, set_h;

    // Stall counter walks 0..iStallPeriod; ready is registered from the next count
    // so tready drops exactly in the cycle the counter sits on iStallPeriod.
    always_comb begin
        stall_d = (stall_q >= iStallPeriod) ? 4'd0 : stall_q + 4'd1;
        ready_d = (iStallPeriod == 4'd0) || (stall_d != iStallPeriod);
    end

    // A tuser transfer always rebases to (0,0), whichever state we are in.
    always_comb begin
        xfer      = s_axis_tvalid & ready_q;
        accept    = xfer & (state_q == S_ACTIVE | s_axis_tuser);
        cx        = s_axis_tuser ? 16'd0 : x_q;
        cy        = s_axis_tuser ? 16'd0 : y_q;
        sum_d     = s_axis_tuser ? 32'(s_axis_tdata) : sum_q + 32'(s_axis_tdata);
        at_xl     = cx == X_LAST;
        eol       = s_axis_tlast | at_xl;
        eof       = eol & (cy == Y_LAST);
        set_sof   = xfer & state_q == S_ACTIVE & s_axis_tuser & x_q != 16'd0;
        set_h     = xfer & ((state_q == S_WAIT_SOF & ~s_axis_tuser & cnt_q != 16'd0) |
                            (state_q == S_ACTIVE & s_axis_tuser & x_q == 16'd0 & y_q != 16'd0));
        set_early = accept & s_axis_tlast & ~at_xl;
        set_late  = accept & at_xl & ~s_axis_tlast;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_WAIT_SOF;
            stall_q     <= 4'd0;
            ready_q     <= 1'b0;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            sum_q       <= 32'd0;
            valid_q     <= 1'b0;
            eof_q       <= 1'b0;
            data_q      <= '0;
            ox_q        <= 16'd0;
            oy_q        <= 16'd0;
            cnt_q       <= 16'd0;
            fsum_q      <= 32'd0;
            err_sof_q   <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            err_h_q     <= 1'b0;
        end else begin
            stall_q     <= stall_d;
            ready_q     <= ready_d;
            valid_q     <= accept;
            eof_q       <= accept & eof;
            err_sof_q   <= set_sof   | (err_sof_q   & ~iClearErr);
            err_early_q <= set_early | (err_early_q & ~iClearErr);
            err_late_q  <= set_late  | (err_late_q  & ~iClearErr);
            err_h_q     <= set_h     | (err_h_q     & ~iClearErr);
            if (accept) begin
                data_q <= s_axis_tdata;
                ox_q   <= cx;
                oy_q   <= cy;
                sum_q  <= sum_d;
                if (eol) begin
                    x_q     <= 16'd0;
                    y_q     <= eof ? 16'd0 : cy + 16'd1;
                    state_q <= eof ? S_WAIT_SOF : S_ACTIVE;
                    if (eof) begin
                        cnt_q  <= cnt_q + 16'd1;
                        fsum_q <= sum_d;
                    end
                end else begin
                    x_q     <= cx + 16'd1;
                    y_q     <= cy;
                    state_q <= S_ACTIVE;
                end
            end
        end
    end

    assign s_axis_tready = ready_q;
    assign oValid        = valid_q;
    assign oData         = data_q;
    assign oX            = ox_q;
    assign oY            = oy_q;
    assign oEndOfFrame   = eof_q;
    assign oFrameCnt     = cnt_q;
    assign oFrameSum     = fsum_q;
    assign oErrSof       = err_sof_q;
    assign oErrEolEarly  = err_early_q;
    assign oErrEolLate   = err_late_q;
    assign oErrHeight    = err_h_q;
endmodule

// File: tb/tb_axis_video_frame_sink.sv
// tb_axis_video_frame_sink: scoreboard bench for axis_video_frame_sink on a 4x2 image
module tb_axis_video_frame_sink;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  stall = 4'd0;
    logic        clr = 1'b0;
    logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
    logic [15:0] tdata = 16'd0;
    logic        tready, o_valid, o_eof;
    logic [15:0] o_data, o_x, o_y, o_cnt;
    logic [31:0] o_sum;
    logic        e_sof, e_early, e_late, e_h;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] x;
        logic [15:0] y;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    axis_video_frame_sink #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
        .clk(clk), .reset(reset), .iStallPeriod(stall), .iClearErr(clr),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tuser(tuser),
        .s_axis_tlast(tlast), .s_axis_tdata(tdata),
        .oValid(o_valid), .oData(o_data), .oX(o_x), .oY(o_y), .oEndOfFrame(o_eof),
        .oFrameCnt(o_cnt), .oFrameSum(o_sum), .oErrSof(e_sof), .oErrEolEarly(e_early),
        .oErrEolLate(e_late), .oErrHeight(e_h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t t;
        if (o_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pixel %0d at (%0d,%0d) expected none", o_data, o_x, o_y);
            end else begin
                t = q.pop_front();
                chk("pix_data", 32'(o_data), 32'(t.d));
                chk("pix_x", 32'(o_x), 32'(t.x));
                chk("pix_y", 32'(o_y), 32'(t.y));
                chk("pix_eof", 32'(o_eof), 32'(t.e));
            end
        end else if (o_eof) begin
            chk("eof_without_valid", 32'(o_eof), 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic u, input logic l, input logic acc,
                        input logic [15:0] ex, input logic [15:0] ey, input logic ee);
        logic r;
        int   n;
        n = 0;
        tvalid = 1'b1;
        tdata  = d;
        tuser  = u;
        tlast  = l;
        if (acc) q.push_back('{d: d, x: ex, y: ey, e: ee});
        do begin
            r = tready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 50);
        if (!r) chk("xfer_timeout", 32'(r), 32'd1);
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic frame_clean();
        for (int i = 0; i < 8; i++)
            send(16'(i + 1), i == 0, i % 4 == 3, 1'b1, 16'(i % 4), 16'(i / 4), i == 7);
    endtask

    task automatic stats(input logic [15:0] cnt, input logic [31:0] sum,
                         input logic s, input logic ee, input logic el, input logic h);
        idle(2);
        chk("frame_cnt", 32'(o_cnt), 32'(cnt));
        chk("frame_sum", o_sum, sum);
        chk("err_sof", 32'(e_sof), 32'(s));
        chk("err_eol_early", 32'(e_early), 32'(ee));
        chk("err_eol_late", 32'(e_late), 32'(el));
        chk("err_height", 32'(e_h), 32'(h));
        chk("sb_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    initial begin
        int z;
        idle(3);
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        chk("rst_sum", o_sum, 32'd0);
        chk("rst_errs", 32'({e_sof, e_early, e_late, e_h}), 32'd0);
        reset = 1'b0;
        chk("tready_before_rise", 32'(tready), 32'd0);
        idle(1);
        chk("tready_after_rise", 32'(tready), 32'd1);

        for (int i = 0; i < 3; i++) send(16'(20 + i), 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        stats(16'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        frame_clean();
        stats(16'd1, 32'd36, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) send(16'(30 + i), 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        stats(16'd1, 32'd36, 1'b0, 1'b0, 1'b0, 1'b1);
        clear_pulse();
        chk("err_height_cleared", 32'(e_h), 32'd0);

        stall = 4'd2;
        idle(1);
        z = 0;
        for (int i = 0; i < 9; i++) begin
            if (!tready) z++;
            idle(1);
        end
        chk("stall_low_cycles", 32'(z), 32'd3);
        frame_clean();
        stats(16'd2, 32'd36, 1'b0, 1'b0, 1'b0, 1'b0);
        stall = 4'd0;
        idle(2);

        send(16'd1, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
        send(16'd2, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0);
        send(16'd3, 1'b0, 1'b1, 1'b1, 16'd2, 16'd0, 1'b0);
        send(16'd4, 1'b0, 1'b0, 1'b1, 16'd0, 16'd1, 1'b0);
        send(16'd5, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b0);
        send(16'd6, 1'b0, 1'b0, 1'b1, 16'd2, 16'd1, 1'b0);
        send(16'd7, 1'b0, 1'b1, 1'b1, 16'd3, 16'd1, 1'b1);
        stats(16'd3, 32'd28, 1'b0, 1'b1, 1'b0, 1'b0);
        clear_pulse();
        chk("err_early_cleared", 32'(e_early), 32'd0);

        send(16'd1, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
        send(16'd2, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0);
        send(16'd3, 1'b0, 1'b0, 1'b1, 16'd2, 16'd0, 1'b0);
        send(16'd4, 1'b0, 1'b0, 1'b1, 16'd3, 16'd0, 1'b0);
        send(16'd5, 1'b0, 1'b0, 1'b1, 16'd0, 16'd1, 1'b0);
        send(16'd6, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
        send(16'd7, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0);
        send(16'd8, 1'b0, 1'b0, 1'b1, 16'd2, 16'd0, 1'b0);
        send(16'd9, 1'b0, 1'b1, 1'b1, 16'd3, 16'd0, 1'b0);
        send(16'd10, 1'b0, 1'b0, 1'b1, 16'd0, 16'd1, 1'b0);
        send(16'd11, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b0);
        send(16'd12, 1'b0, 1'b0, 1'b1, 16'd2, 16'd1, 1'b0);
        send(16'd13, 1'b0, 1'b1, 1'b1, 16'd3, 16'd1, 1'b1);
        stats(16'd4, 32'd76, 1'b1, 1'b0, 1'b1, 1'b0);
        clear_pulse();
        chk("err_sof_cleared", 32'(e_sof), 32'd0);
        chk("err_late_cleared", 32'(e_late), 32'd0);

        send(16'd1, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
        send(16'd2, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0);
        send(16'd3, 1'b0, 1'b0, 1'b1, 16'd2, 16'd0, 1'b0);
        idle(2);
        reset = 1'b1;
        idle(1);
        chk("midrst_tready", 32'(tready), 32'd0);
        chk("midrst_cnt", 32'(o_cnt), 32'd0);
        chk("midrst_sum", o_sum, 32'd0);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        reset = 1'b0;
        idle(2);
        frame_clean();
        stats(16'd1, 32'd36, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
